range_sequencer: RTL and testbench

- Control FSM between the debounced pushbutton/switch front end and the Collatz `range` engine.
- Lets the user set a 32-bit start value, launches a `range` run with a one-cycle `go`, and waits for `done`.
- After the run, lets the user browse the RAM_WORDS results by stepping the RAM read address `n`.
- Provides auto-repeat on held inc/dec buttons, and registered display values for the hex7seg digits and LEDs.

---
 rtl/range_sequencer_if.sv | 27 ++
 rtl/range_sequencer.sv | 125 ++++++++++++
 tb/tb_range_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/range_sequencer_if.sv
// Bundle between the button/switch front end, the range engine and the
// range_sequencer control FSM.
interface range_sequencer_if #(
  parameter int RAM_ADDR_BITS = 8
);
  logic [9:0]               sw;
  logic                     c_inc, c_dec, h_inc, h_dec, c_load, c_go;
  logic                     done;
  logic [15:0]              count;
  logic                     go;
  logic [31:0]              start;
  logic [RAM_ADDR_BITS-1:0] n;
  logic [11:0]              disp_value;
  logic [15:0]              disp_count;
  logic                     busy;
  logic                     browsing;

  modport slave (
    input  sw, c_inc, c_dec, h_inc, h_dec, c_load, c_go, done, count,
    output go, start, n, disp_value, disp_count, busy, browsing
  );

  modport master (
    output sw, c_inc, c_dec, h_inc, h_dec, c_load, c_go, done, count,
    input  go, start, n, disp_value, disp_count, busy, browsing
  );
endinterface

// File: rtl/range_sequencer.sv
// Control FSM: set a start value, launch a Collatz range run, then browse
// the results by stepping the RAM read address. Includes button auto-repeat.
module range_sequencer #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  range_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {SETUP, LAUNCH, RUN, BROWSE} state_t;

  localparam logic [31:0]              DLY     = 32'(REPEAT_DELAY);
  localparam logic [31:0]              PER     = 32'(REPEAT_PERIOD);
  localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state_q;
  logic [31:0]              base_q;
  logic [RAM_ADDR_BITS-1:0] offset_q;
  logic                     go_q;
  logic                     run_first_q;
  logic [15:0]              disp_count_q;

  // Auto-repeat: index 0 = inc, 1 = dec. Phase 0 waits DLY, phase 1 waits PER.
  logic [1:0]        held;
  logic [1:0][31:0]  rcnt_q, rcnt_d;
  logic [1:0]        rph_q, rph_d, rfire;

  assign held = {bus.h_dec, bus.h_inc};

  always_comb begin
    rcnt_d = '0;
    rph_d  = '0;
    rfire  = '0;
    for (int i = 0; i < 2; i++) begin
      if (held[i]) begin
        if (rcnt_q[i] + 32'd1 == (rph_q[i] ? PER : DLY)) begin
          rfire[i] = 1'b1;
          rph_d[i] = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 32'd1;
          rph_d[i]  = rph_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_q <= '0;
      rph_q  <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      rph_q  <= rph_d;
    end
  end

  // Opposing steps in the same cycle cancel.
  logic up_req, dn_req, step_up, step_dn;
  assign up_req  = bus.c_inc | rfire[0];
  assign dn_req  = bus.c_dec | rfire[1];
  assign step_up = up_req & ~dn_req;
  assign step_dn = dn_req & ~up_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SETUP;
      base_q       <= 32'd1;
      offset_q     <= '0;
      go_q         <= 1'b0;
      run_first_q  <= 1'b0;
      disp_count_q <= '0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        SETUP: begin
          if (bus.c_load)
            base_q <= (bus.sw == 10'd0) ? 32'd1 : {22'd0, bus.sw};
          else if (step_up && base_q != 32'hFFFF_FFFF)
            base_q <= base_q + 32'd1;
          else if (step_dn && base_q > 32'd1)
            base_q <= base_q - 32'd1;
          if (bus.c_go) begin
            state_q <= LAUNCH;
            go_q    <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q     <= RUN;
          run_first_q <= 1'b1;
        end
        RUN: begin
          // A done still high from the previous run is ignored on entry.
          run_first_q <= 1'b0;
          if (!run_first_q && bus.done) begin
            offset_q <= '0;
            state_q  <= BROWSE;
          end
        end
        BROWSE: begin
          disp_count_q <= bus.count;
          if (bus.c_go) begin
            state_q  <= SETUP;
            offset_q <= '0;
          end else if (step_up)
            offset_q <= (offset_q == OFF_MAX) ? '0 : offset_q + 1'b1;
          else if (step_dn)
            offset_q <= (offset_q == '0) ? OFF_MAX : offset_q - 1'b1;
        end
        default: state_q <= SETUP;
      endcase
    end
  end

  assign bus.go         = go_q;
  assign bus.start      = base_q;
  assign bus.n          = offset_q;
  assign bus.disp_count = disp_count_q;
  assign bus.busy       = (state_q == LAUNCH) || (state_q == RUN);
  assign bus.browsing   = (state_q == BROWSE);
  assign bus.disp_value = (state_q == BROWSE) ? (base_q[11:0] + 12'(offset_q))
                                              : base_q[11:0];
endmodule

// File: tb/tb_range_sequencer.sv
// Directed bench for range_sequencer with short auto-repeat timing and a
// behavioural RAM returning n ^ 0x0A5A one cycle after n changes.
module tb_range_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  range_sequencer_if #(.RAM_ADDR_BITS(8)) bus();

  range_sequencer #(
    .RAM_WORDS(256), .RAM_ADDR_BITS(8), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.count <= {8'h00, bus.n} ^ 16'h0A5A;

  task automatic tick(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [9:0] v);
    bus.sw = v; bus.c_load = 1'b1; tick(); bus.c_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    total++; if (bus.start !== 32'd1) $display("FAIL reset_start got %h want 00000001", bus.start); else passed++;
    total++; if (bus.n !== 8'd0) $display("FAIL reset_n got %h want 00", bus.n); else passed++;
    total++; if (bus.disp_value !== 12'h001) $display("FAIL reset_disp_value got %h want 001", bus.disp_value); else passed++;
    total++; if ({bus.go, bus.busy, bus.browsing} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.go, bus.busy, bus.browsing}); else passed++;
    total++; if (bus.disp_count !== 16'h0) $display("FAIL reset_disp_count got %h want 0000", bus.disp_count); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load();
    load(10'h000);
    total++; if (bus.start !== 32'd1) $display("FAIL load_zero got %h want 00000001", bus.start); else passed++;
    load(10'h01B);
    total++; if (bus.start !== 32'h0000_001B) $display("FAIL load_start got %h want 0000001b", bus.start); else passed++;
    total++; if (bus.disp_value !== 12'h01B) $display("FAIL load_disp_value got %h want 01b", bus.disp_value); else passed++;
    total++; if ({bus.busy, bus.browsing} !== 2'b00) $display("FAIL load_state got %b want 00", {bus.busy, bus.browsing}); else passed++;
    // load wins over a simultaneous step
    bus.sw = 10'h040; bus.c_load = 1'b1; bus.c_inc = 1'b1; tick(); bus.c_load = 1'b0; bus.c_inc = 1'b0;
    total++; if (bus.start !== 32'h40) $display("FAIL load_priority got %h want 00000040", bus.start); else passed++;
  endtask

  task automatic test_bounds();
    load(10'h001);
    bus.c_dec = 1'b1; tick(); bus.c_dec = 1'b0;
    total++; if (bus.start !== 32'd1) $display("FAIL dec_clamp got %h want 00000001", bus.start); else passed++;
    force dut.base_q = 32'hFFFF_FFFF;
    tick();
    release dut.base_q;
    tick();
    bus.c_inc = 1'b1; tick(); bus.c_inc = 1'b0;
    total++; if (bus.start !== 32'hFFFF_FFFF) $display("FAIL inc_saturate got %h want ffffffff", bus.start); else passed++;
    bus.c_dec = 1'b1; tick(); bus.c_dec = 1'b0;
    total++; if (bus.start !== 32'hFFFF_FFFE) $display("FAIL dec_from_max got %h want fffffffe", bus.start); else passed++;
    load(10'h01B);
    bus.c_inc = 1'b1; bus.c_dec = 1'b1; tick(); bus.c_inc = 1'b0; bus.c_dec = 1'b0;
    total++; if (bus.start !== 32'd27) $display("FAIL inc_dec_cancel got %h want 0000001b", bus.start); else passed++;
  endtask

  task automatic test_autorepeat();
    load(10'd5);
    bus.h_inc = 1'b1;
    tick(9);
    total++; if (bus.start !== 32'd5) $display("FAIL rpt_before_delay got %0d want 5", bus.start); else passed++;
    tick();
    total++; if (bus.start !== 32'd6) $display("FAIL rpt_first got %0d want 6", bus.start); else passed++;
    tick(12);
    total++; if (bus.start !== 32'd9) $display("FAIL rpt_22_cycles got %0d want 9", bus.start); else passed++;
    bus.h_inc = 1'b0;
    tick(12);
    total++; if (bus.start !== 32'd9) $display("FAIL rpt_release got %0d want 9", bus.start); else passed++;
    bus.h_dec = 1'b1; tick(10); bus.h_dec = 1'b0;
    total++; if (bus.start !== 32'd8) $display("FAIL rpt_dec_restart got %0d want 8", bus.start); else passed++;
  endtask

  task automatic test_launch_run();
    load(10'h01B);
    bus.done = 1'b1;
    bus.c_go = 1'b1; tick(); bus.c_go = 1'b0;
    total++; if ({bus.go, bus.busy} !== 2'b11) $display("FAIL launch_go got %b want 11", {bus.go, bus.busy}); else passed++;
    tick();
    total++; if ({bus.go, bus.busy, bus.browsing} !== 3'b010) $display("FAIL run_go_drop got %b want 010", {bus.go, bus.busy, bus.browsing}); else passed++;
    tick();
    total++; if (bus.browsing !== 1'b0) $display("FAIL stale_done got %b want 0", bus.browsing); else passed++;
    bus.done = 1'b0;
    bus.sw = 10'h3FF; bus.c_go = 1'b1; bus.c_load = 1'b1; bus.c_inc = 1'b1; tick();
    bus.c_go = 1'b0; bus.c_load = 1'b0; bus.c_inc = 1'b0;
    total++; if (bus.start !== 32'd27 || bus.busy !== 1'b1 || bus.go !== 1'b0) $display("FAIL run_ignore got start=%h busy=%b go=%b want 0000001b 1 0", bus.start, bus.busy, bus.go); else passed++;
    tick(49);
    total++; if (bus.busy !== 1'b1) $display("FAIL run_hold got %b want 1", bus.busy); else passed++;
    bus.done = 1'b1; tick();
    total++; if ({bus.browsing, bus.busy} !== 2'b10) $display("FAIL run_exit got %b want 10", {bus.browsing, bus.busy}); else passed++;
    total++; if (bus.n !== 8'd0) $display("FAIL browse_n0 got %h want 00", bus.n); else passed++;
    total++; if (bus.disp_value !== 12'h01B) $display("FAIL browse_dv0 got %h want 01b", bus.disp_value); else passed++;
    bus.done = 1'b0;
  endtask

  task automatic test_browse();
    bus.c_dec = 1'b1; tick(); bus.c_dec = 1'b0;
    total++; if (bus.n !== 8'd255) $display("FAIL browse_wrap_dn got %0d want 255", bus.n); else passed++;
    total++; if (bus.disp_value !== 12'h11A) $display("FAIL browse_dv255 got %h want 11a", bus.disp_value); else passed++;
    tick();
    total++; if (bus.disp_count === 16'h0AA5) $display("FAIL browse_count_early got %h want not 0aa5", bus.disp_count); else passed++;
    tick();
    total++; if (bus.disp_count !== 16'h0AA5) $display("FAIL browse_count255 got %h want 0aa5", bus.disp_count); else passed++;
    bus.sw = 10'h3FF; bus.c_load = 1'b1; tick(); bus.c_load = 1'b0;
    total++; if (bus.n !== 8'd255 || bus.browsing !== 1'b1) $display("FAIL browse_load_ignored got n=%0d browsing=%b want 255 1", bus.n, bus.browsing); else passed++;
    bus.c_inc = 1'b1; tick(); bus.c_inc = 1'b0;
    total++; if (bus.n !== 8'd0) $display("FAIL browse_wrap_up got %0d want 0", bus.n); else passed++;
    tick(2);
    total++; if (bus.disp_count !== 16'h0A5A) $display("FAIL browse_count0 got %h want 0a5a", bus.disp_count); else passed++;
    bus.c_inc = 1'b1; tick(); bus.c_inc = 1'b0; tick(2);
    total++; if (bus.n !== 8'd1 || bus.disp_count !== 16'h0A5B) $display("FAIL browse_step1 got n=%0d dc=%h want 1 0a5b", bus.n, bus.disp_count); else passed++;
    bus.c_go = 1'b1; tick(); bus.c_go = 1'b0;
    total++; if ({bus.browsing, bus.busy} !== 2'b00 || bus.start !== 32'd27 || bus.n !== 8'd0) $display("FAIL browse_exit got st=%b start=%h n=%0d want 00 0000001b 0", {bus.browsing, bus.busy}, bus.start, bus.n); else passed++;
    total++; if (bus.disp_value !== 12'h01B) $display("FAIL setup_dv got %h want 01b", bus.disp_value); else passed++;
  endtask

  task automatic test_reset_mid_run();
    bus.c_go = 1'b1; tick(); bus.c_go = 1'b0;
    tick();
    total++; if (bus.busy !== 1'b1) $display("FAIL midrun_busy got %b want 1", bus.busy); else passed++;
    reset = 1'b1;
    #2;
    total++; if ({bus.go, bus.busy, bus.browsing} !== 3'b000 || bus.start !== 32'd1) $display("FAIL midrun_reset got flags=%b start=%h want 000 00000001", {bus.go, bus.busy, bus.browsing}, bus.start); else passed++;
    tick();
    reset = 1'b0;
    tick();
    bus.c_inc = 1'b1; tick(); bus.c_inc = 1'b0;
    total++; if (bus.start !== 32'd2) $display("FAIL after_reset_setup got %0d want 2", bus.start); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bus.sw = '0; bus.c_inc = 0; bus.c_dec = 0; bus.h_inc = 0; bus.h_dec = 0;
    bus.c_load = 0; bus.c_go = 0; bus.done = 0;
    test_reset();
    test_load();
    test_bounds();
    test_autorepeat();
    test_launch_run();
    test_browse();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
